// File: rtl/cla8_seq_ctrl.sv
// rtl/cla8_seq_ctrl.sv - sequencer that time-shares one 8-bit CLA slice for WORDS*8-bit adds
//
// Purpose:
//   Holds both operands and walks the external CLA from the least-significant byte upwards.
//   Each slice is presented for SETTLE cycles before its sum byte and carry are captured.
//   Requests and results each use a valid/ready handshake. A result accept and a new request
//   can happen in the same cycle, so back-to-back operations have no idle cycle between them.
//
// Optional feature:
//   Define CLA8_SEQ_SUB_EN to add input in_sub, which is sampled at accept. When in_sub=1 the
//   block computes A - B as A + ~B + 1, and out_cout=1 means no borrow.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready                request handshake
//   in_a, in_b, in_cin               operands and carry in (8*WORDS bits wide)
//   in_sub                           subtract select (only with CLA8_SEQ_SUB_EN)
//   out_valid/out_ready              result handshake
//   out_sum, out_cout                result and carry out of the top slice
//   busy                             high while slices are being processed
//   cla_a, cla_b, cla_cin            drive the external CLA slice
//   cla_sum, cla_cout                returned from the external CLA slice

module cla8_seq_ctrl #(
  parameter int WORDS  = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*WORDS-1:0]   in_a,
  input  logic [8*WORDS-1:0]   in_b,
  input  logic                 in_cin,
`ifdef CLA8_SEQ_SUB_EN
  input  logic                 in_sub,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*WORDS-1:0]   out_sum,
  output logic                 out_cout,
  output logic                 busy,
  output logic [7:0]           cla_a,
  output logic [7:0]           cla_b,
  output logic                 cla_cin,
  input  logic [7:0]           cla_sum,
  input  logic                 cla_cout
);

  localparam int W    = 8 * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WORDS - 1);
  localparam logic [3:0]      CNT_LOAD = 4'(SETTLE - 1);

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q,   idx_d;
  logic [3:0]      cnt_q,   cnt_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q,     a_d;
  logic [W-1:0]    b_q,     b_d;
  logic [W-1:0]    sum_q,   sum_d;
  logic            cout_q,  cout_d;

  logic            accept;
  logic [W-1:0]    b_acc;
  logic            cin_acc;
  logic [7:0]      slice_a, slice_b;

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

`ifdef CLA8_SEQ_SUB_EN
  // Subtraction as A + ~B + 1: the +1 rides in on the slice-0 carry.
  assign b_acc   = in_sub ? ~in_b : in_b;
  assign cin_acc = in_sub | in_cin;
`else
  assign b_acc   = in_b;
  assign cin_acc = in_cin;
`endif

  // Byte select by constant-index compare; the CLA sees only registered values, so its
  // inputs cannot glitch within a slice.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx_q == IDXW'(w)) begin
        slice_a = a_q[8*w +: 8];
        slice_b = b_q[8*w +: 8];
      end
    end
  end

  assign cla_a   = busy ? slice_a : 8'h00;
  assign cla_b   = busy ? slice_b : 8'h00;
  assign cla_cin = busy ? carry_q : 1'b0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      ST_IDLE: ;
      ST_RUN: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          for (int w = 0; w < WORDS; w++) begin
            if (idx_q == IDXW'(w)) sum_d[8*w +: 8] = cla_sum;
          end
          carry_d = cla_cout;
          if (idx_q == IDX_LAST) begin
            cout_d  = cla_cout;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDXW'(1);
            cnt_d = CNT_LOAD;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // accept is only possible in IDLE or at the DONE handshake, so it overrides the case above.
    if (accept) begin
      a_d     = in_a;
      b_d     = b_acc;
      carry_d = cin_acc;
      idx_d   = '0;
      cnt_d   = CNT_LOAD;
      sum_d   = '0;
      cout_d  = 1'b0;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: tb/tb_cla8_seq_ctrl.sv
// tb/tb_cla8_seq_ctrl.sv - directed self-checking bench for cla8_seq_ctrl

module tb_cla8_seq_ctrl;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, in_cin;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready, out_cout, busy;
  logic [31:0] out_sum;
  logic [7:0]  cla_a, cla_b, cla_sum;
  logic        cla_cin, cla_cout;

  logic        in_valid1, in_ready1, in_cin1;
  logic [7:0]  in_a1, in_b1;
  logic        out_valid1, out_ready1, out_cout1, busy1;
  logic [7:0]  out_sum1;
  logic [7:0]  cla_a1, cla_b1, cla_sum1;
  logic        cla_cin1, cla_cout1;

`ifdef CLA8_SEQ_SUB_EN
  logic        in_sub;
  logic        in_sub1;
`endif

  int checks;
  int failures;

  logic [7:0]  obs_a    [0:31];
  logic [7:0]  obs_b    [0:31];
  logic        obs_cin  [0:31];
  logic        obs_busy [0:31];
  logic [31:0] obs_sum  [0:31];

  // Ideal combinational CLA models
  assign {cla_cout, cla_sum}   = {1'b0, cla_a} + {1'b0, cla_b} + {8'h00, cla_cin};
  assign {cla_cout1, cla_sum1} = {1'b0, cla_a1} + {1'b0, cla_b1} + {8'h00, cla_cin1};

  cla8_seq_ctrl #(.WORDS(4), .SETTLE(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef CLA8_SEQ_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy),
    .cla_a     (cla_a),
    .cla_b     (cla_b),
    .cla_cin   (cla_cin),
    .cla_sum   (cla_sum),
    .cla_cout  (cla_cout)
  );

  cla8_seq_ctrl #(.WORDS(1), .SETTLE(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_a      (in_a1),
    .in_b      (in_b1),
    .in_cin    (in_cin1),
`ifdef CLA8_SEQ_SUB_EN
    .in_sub    (in_sub1),
`endif
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_sum   (out_sum1),
    .out_cout  (out_cout1),
    .busy      (busy1),
    .cla_a     (cla_a1),
    .cla_b     (cla_b1),
    .cla_cin   (cla_cin1),
    .cla_sum   (cla_sum1),
    .cla_cout  (cla_cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic cin);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    check("accept_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_cin   = 1'b0;
  endtask

  // Samples each negedge after the accept edge; lat = edges from accept to out_valid.
  task automatic observe(output int lat);
    lat = -1;
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      obs_a[n]    = cla_a;
      obs_b[n]    = cla_b;
      obs_cin[n]  = cla_cin;
      obs_busy[n] = busy;
      obs_sum[n]  = out_sum;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_ov_after"}, out_valid, 1'b0);
    check({tag, "_ir_after"}, in_ready, 1'b1);
  endtask

  initial begin
    int lat;
    logic [31:0] va;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_cin1 = 1'b0; out_ready1 = 1'b0;
`ifdef CLA8_SEQ_SUB_EN
    in_sub = 1'b0;
    in_sub1 = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_sum", out_sum, 32'h0);
    check("rst_out_cout", out_cout, 1'b0);
    check("rst_cla", {cla_a, cla_b, cla_cin}, 17'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: full carry ripple
    accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    observe(lat);
    check("t1_latency", lat, 8);
    check("t1_cin_s0", obs_cin[0], 1'b0);
    check("t1_cin_s1", obs_cin[2], 1'b1);
    check("t1_cin_s2", obs_cin[4], 1'b1);
    check("t1_cin_s3", obs_cin[6], 1'b1);
    check("t1_b_s0", obs_b[0], 8'h01);
    check("t1_b_s1", obs_b[2], 8'h00);
    check("t1_sum", out_sum, 32'h0000_0000);
    check("t1_cout", out_cout, 1'b1);
    drain("t1");

    // T2: mixed bytes with cin, slice hold time
    accept(32'h1234_5678, 32'h1111_1111, 1'b1);
    observe(lat);
    check("t2_latency", lat, 8);
    va = 32'h1234_5678;
    for (int n = 0; n < 8; n++) begin
      check($sformatf("t2_a_n%0d", n), obs_a[n], va[8*(n/2) +: 8]);
      check($sformatf("t2_b_n%0d", n), obs_b[n], 8'h11);
    end
    check("t2_sum", out_sum, 32'h2345_678A);
    check("t2_cout", out_cout, 1'b0);
    drain("t2");

    // T3: backpressure then back-to-back accept
    accept(32'h0000_0001, 32'h0000_0002, 1'b0);
    observe(lat);
    check("t3_latency", lat, 8);
    in_a = 32'h0000_0010; in_b = 32'h0000_0020; in_cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_hold_ready%0d", i), in_ready, 1'b0);
      check($sformatf("t3_hold_sum%0d", i), out_sum, 32'h0000_0003);
      check($sformatf("t3_hold_valid%0d", i), out_valid, 1'b1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("t3_ready_on_hs", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    observe(lat);
    check("t3_busy_next", obs_busy[0], 1'b1);
    check("t3_sum_cleared", obs_sum[0], 32'h0);
    check("t3_b2b_latency", lat, 8);
    check("t3_b2b_sum", out_sum, 32'h0000_0030);
    drain("t3");

    // T4: reset during slice 2
    accept(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    repeat (5) @(negedge clk);
    check("t4_pre_rst_a", cla_a, 8'hAA);
    rst_n = 1'b0;
    #1;
    check("t4_rst_valid", out_valid, 1'b0);
    check("t4_rst_ready", in_ready, 1'b1);
    check("t4_rst_busy", busy, 1'b0);
    check("t4_rst_cla", {cla_a, cla_b, cla_cin}, 17'h0);
    check("t4_rst_sum", out_sum, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    accept(32'h0000_0005, 32'h0000_0003, 1'b0);
    observe(lat);
    check("t4_latency", lat, 8);
    check("t4_sum", out_sum, 32'h0000_0008);
    check("t4_cout", out_cout, 1'b0);
    drain("t4");

    // T5: WORDS=1, SETTLE=1 instance
    in_a1 = 8'h80; in_b1 = 8'h80; in_cin1 = 1'b0; in_valid1 = 1'b1;
    check("t5_ready", in_ready1, 1'b1);
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    check("t5_valid_n0", out_valid1, 1'b0);
    check("t5_busy_n0", busy1, 1'b1);
    check("t5_cla_a", cla_a1, 8'h80);
    @(negedge clk);
    check("t5_valid_n1", out_valid1, 1'b1);
    check("t5_sum", out_sum1, 8'h00);
    check("t5_cout", out_cout1, 1'b1);

`ifdef CLA8_SEQ_SUB_EN
    // T6: subtraction
    in_sub = 1'b1;
    accept(32'h0000_0005, 32'h0000_0007, 1'b0);
    observe(lat);
    check("t6_sub1_sum", out_sum, 32'hFFFF_FFFE);
    check("t6_sub1_cout", out_cout, 1'b0);
    drain("t6a");
    accept(32'h0000_0007, 32'h0000_0005, 1'b0);
    observe(lat);
    check("t6_sub2_sum", out_sum, 32'h0000_0002);
    check("t6_sub2_cout", out_cout, 1'b1);
    drain("t6b");
    in_sub = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
